// File: rtl/filter_pkg.sv
// filter_pkg: shared mode codes, window tap indices and box-scale constants
// for the 3x3 window filter.
package filter_pkg;
    localparam logic [2:0] MODE_PASS  = 3'd0;
    localparam logic [2:0] MODE_BOX   = 3'd1;
    localparam logic [2:0] MODE_GAUSS = 3'd2;
    localparam logic [2:0] MODE_SHARP = 3'd3;
    localparam logic [2:0] MODE_SOBEL = 3'd4;
    // Row-major tap order; tap k sits at bits [(8-k)*PIX_W +: PIX_W] of the window.
    localparam int T00 = 0;
    localparam int T01 = 1;
    localparam int T02 = 2;
    localparam int T10 = 3;
    localparam int T11 = 4;
    localparam int T12 = 5;
    localparam int T20 = 6;
    localparam int T21 = 7;
    localparam int T22 = 8;
    localparam int BOX_MUL   = 57;
    localparam int BOX_SHIFT = 9;
endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: clamps a signed value into the unsigned PIX_W-bit pixel range.
module sat_clamp #(
    parameter int IN_W  = 8,
    parameter int PIX_W = 4
) (
    input  logic signed [IN_W-1:0] val_i,
    output logic [PIX_W-1:0]       pix_o
);
    localparam logic signed [IN_W-1:0] PIX_MAX = IN_W'((1 << PIX_W) - 1);
    always_comb pix_o = val_i[IN_W-1] ? '0 : (val_i > PIX_MAX) ? '1 : val_i[PIX_W-1:0];
endmodule

// File: rtl/window_filter_3x3.sv
// window_filter_3x3: three-stage 3x3 kernel filter (pass/box/Gaussian/sharpen/Sobel)
// with output raster coordinates and an end-of-frame pulse.
module window_filter_3x3
    import filter_pkg::*;
#(
    parameter int PIX_W = 4,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9*PIX_W-1:0] win_in,
    input  logic               win_valid,
    input  logic               sof_in,
    input  logic [2:0]         mode,
    output logic [PIX_W-1:0]   pix_out,
    output logic               pix_valid,
    output logic [8:0]         out_x,
    output logic [7:0]         out_y,
    output logic               eof_out
);
    localparam int RW = PIX_W + 2;
    localparam int AW = PIX_W + 3;
    localparam int SW = PIX_W + 4;
    localparam logic [8:0] X_MAX = 9'(IMG_W - 1);
    localparam logic [7:0] Y_MAX = 8'(IMG_H - 1);

    function automatic logic [RW-1:0] sum3(input logic [PIX_W-1:0] a, b, c);
        return RW'(a) + RW'(b) + RW'(c);
    endfunction

    function automatic logic [RW-1:0] w121(input logic [PIX_W-1:0] a, b, c);
        return RW'(a) + RW'({b, 1'b0}) + RW'(c);
    endfunction

    logic [PIX_W-1:0] p [9];
    logic [2:0]       mode_q, mode_d;
    logic             s1_v_q, s1_sof_q;
    logic [2:0]       s1_mode_q;
    logic [PIX_W-1:0] s1_c_q;
    logic [RW-1:0]    s1_row_q [3];
    logic [RW-1:0]    s1_wrow_q [3];
    logic [RW-1:0]    s1_lcol_q, s1_rcol_q;
    logic [AW-1:0]    s1_ctr5_q;
    logic [PIX_W:0]   s1_nv_q, s1_nh_q;

    always_comb begin
        for (int k = 0; k < 9; k++) p[k] = win_in[(8-k)*PIX_W +: PIX_W];
    end

    // The sof window already uses the freshly sampled mode.
    assign mode_d = (win_valid && sof_in) ? mode : mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_PASS;
            s1_v_q    <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_mode_q <= MODE_PASS;
            s1_c_q    <= '0;
            s1_row_q  <= '{default: '0};
            s1_wrow_q <= '{default: '0};
            s1_lcol_q <= '0;
            s1_rcol_q <= '0;
            s1_ctr5_q <= '0;
            s1_nv_q   <= '0;
            s1_nh_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            s1_v_q    <= win_valid;
            s1_sof_q  <= win_valid && sof_in;
            s1_mode_q <= mode_d;
            s1_c_q    <= p[T11];
            for (int r = 0; r < 3; r++) begin
                s1_row_q[r]  <= sum3(p[3*r], p[3*r+1], p[3*r+2]);
                s1_wrow_q[r] <= w121(p[3*r], p[3*r+1], p[3*r+2]);
            end
            s1_lcol_q <= w121(p[T00], p[T10], p[T20]);
            s1_rcol_q <= w121(p[T02], p[T12], p[T22]);
            s1_ctr5_q <= AW'({p[T11], 2'b00}) + AW'(p[T11]);
            s1_nv_q   <= (PIX_W+1)'(p[T01]) + (PIX_W+1)'(p[T21]);
            s1_nh_q   <= (PIX_W+1)'(p[T10]) + (PIX_W+1)'(p[T12]);
        end
    end

    logic signed [RW:0] gx, gy;
    logic [RW:0]        ax, ay;
    logic               s2_v_q, s2_sof_q;
    logic [2:0]         s2_mode_q;
    logic [PIX_W-1:0]   s2_c_q;
    logic [SW-1:0]      s2_box_q, s2_gau_q, s2_sob_q;
    logic signed [SW-1:0] s2_shp_q;

    // Sobel reuses the 1-2-1 top/bottom rows as the gy terms.
    always_comb begin
        gx = $signed({1'b0, s1_rcol_q}) - $signed({1'b0, s1_lcol_q});
        gy = $signed({1'b0, s1_wrow_q[2]}) - $signed({1'b0, s1_wrow_q[0]});
        ax = gx[RW] ? -gx : gx;
        ay = gy[RW] ? -gy : gy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q    <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_mode_q <= MODE_PASS;
            s2_c_q    <= '0;
            s2_box_q  <= '0;
            s2_gau_q  <= '0;
            s2_shp_q  <= '0;
            s2_sob_q  <= '0;
        end else begin
            s2_v_q    <= s1_v_q;
            s2_sof_q  <= s1_sof_q;
            s2_mode_q <= s1_mode_q;
            s2_c_q    <= s1_c_q;
            s2_box_q  <= SW'(s1_row_q[0]) + SW'(s1_row_q[1]) + SW'(s1_row_q[2]);
            s2_gau_q  <= SW'(s1_wrow_q[0]) + SW'({s1_wrow_q[1], 1'b0}) + SW'(s1_wrow_q[2]);
            s2_shp_q  <= SW'(s1_ctr5_q) - SW'(s1_nv_q) - SW'(s1_nh_q);
            s2_sob_q  <= SW'(ax) + SW'(ay);
        end
    end

    logic [SW+5:0]    box_prod;
    logic [PIX_W-1:0] shp_pix, sob_pix, res;
    logic             wrap;
    logic [8:0]       x_d, out_x_q;
    logic [7:0]       y_d, out_y_q;
    logic [PIX_W-1:0] pix_q;
    logic             pix_valid_q, eof_q;

    sat_clamp #(.IN_W(SW), .PIX_W(PIX_W)) u_sharp (.val_i(s2_shp_q), .pix_o(shp_pix));
    sat_clamp #(.IN_W(SW), .PIX_W(PIX_W)) u_sobel (.val_i($signed(s2_sob_q)), .pix_o(sob_pix));

    always_comb begin
        box_prod = (SW+6)'(s2_box_q) * (SW+6)'(BOX_MUL);
        res = s2_mode_q == MODE_BOX   ? PIX_W'(box_prod >> BOX_SHIFT)
            : s2_mode_q == MODE_GAUSS ? PIX_W'(s2_gau_q >> 4)
            : s2_mode_q == MODE_SHARP ? shp_pix
            : s2_mode_q == MODE_SOBEL ? sob_pix
            : s2_c_q;
        wrap = out_x_q == X_MAX;
        x_d  = (s2_sof_q || wrap) ? '0 : out_x_q + 9'd1;
        y_d  = s2_sof_q ? '0 : !wrap ? out_y_q : (out_y_q == Y_MAX) ? '0 : out_y_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            eof_q       <= 1'b0;
        end else begin
            pix_valid_q <= s2_v_q;
            eof_q       <= s2_v_q && x_d == X_MAX && y_d == Y_MAX;
            if (s2_v_q) begin
                pix_q   <= res;
                out_x_q <= x_d;
                out_y_q <= y_d;
            end
        end
    end

    assign pix_out   = pix_q;
    assign pix_valid = pix_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign eof_out   = eof_q;
endmodule

// File: tb/tb_window_filter_3x3.sv
// tb_window_filter_3x3: random and directed stimulus against a behavioural
// kernel/raster model with a 3-deep expectation queue.
module tb_window_filter_3x3;
    localparam int IMG_W = 320;
    localparam int IMG_H = 240;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [35:0] win_in = '0;
    logic        win_valid = 1'b0;
    logic        sof_in = 1'b0;
    logic [2:0]  mode = '0;
    logic [3:0]  pix_out;
    logic        pix_valid;
    logic [8:0]  out_x;
    logic [7:0]  out_y;
    logic        eof_out;

    typedef struct {
        bit v;
        int pix;
        int x;
        int y;
        bit eof;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   mode_m, lp, lx, ly;
    int   n_valid, n_eof, eof_x, eof_y;
    int   w[9];

    window_filter_3x3 dut (
        .clk(clk), .rst_n(rst_n), .win_in(win_in), .win_valid(win_valid),
        .sof_in(sof_in), .mode(mode), .pix_out(pix_out), .pix_valid(pix_valid),
        .out_x(out_x), .out_y(out_y), .eof_out(eof_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp15(input int v);
        return v < 0 ? 0 : v > 15 ? 15 : v;
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Kernel results straight from the arithmetic definitions.
    function automatic int ref_pix(input int m, input int t[9]);
        int s, gx, gy;
        s = 0;
        case (m)
            1: begin
                foreach (t[k]) s += t[k];
                return (s * 57) / 512;
            end
            2: return (t[0] + 2*t[1] + t[2] + 2*t[3] + 4*t[4] + 2*t[5] + t[6] + 2*t[7] + t[8]) / 16;
            3: return clamp15(5*t[4] - t[1] - t[3] - t[5] - t[7]);
            4: begin
                gx = (t[2] + 2*t[5] + t[8]) - (t[0] + 2*t[3] + t[6]);
                gy = (t[6] + 2*t[7] + t[8]) - (t[0] + 2*t[1] + t[2]);
                return clamp15(iabs(gx) + iabs(gy));
            end
            default: return t[4];
        endcase
    endfunction

    function automatic logic [35:0] pack(input int t[9]);
        logic [35:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[(8-k)*4 +: 4] = 4'(t[k]);
        return r;
    endfunction

    task automatic model_reset();
        mode_m = 0; lp = 0; lx = 0; ly = 0;
        q.delete();
        repeat (2) q.push_back('{v: 1'b0, pix: 0, x: 0, y: 0, eof: 1'b0});
    endtask

    task automatic step(input bit v, input bit sof, input int md, input int t[9]);
        exp_t e;
        int   i;
        if (v && sof) mode_m = md;
        if (v) begin
            lp = ref_pix(mode_m, t);
            i = sof ? 0 : (ly * IMG_W + lx + 1) % (IMG_W * IMG_H);
            lx = i % IMG_W;
            ly = i / IMG_W;
        end
        e = '{v: v, pix: lp, x: lx, y: ly, eof: v && lx == IMG_W-1 && ly == IMG_H-1};
        q.push_back(e);
        win_valid = v; sof_in = sof; mode = 3'(md); win_in = pack(t);
        @(posedge clk); #1;
        if (pix_valid) n_valid++;
        if (eof_out) begin n_eof++; eof_x = out_x; eof_y = out_y; end
        if (q.size() == 3) begin
            e = q.pop_front();
            check("pix_valid", pix_valid, e.v);
            check("pix_out", pix_out, e.pix);
            check("out_x", out_x, e.x);
            check("out_y", out_y, e.y);
            check("eof_out", eof_out, e.eof);
        end
    endtask

    task automatic do_reset();
        win_valid = 1'b0; sof_in = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_out", pix_out, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_eof", eof_out, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill(input int v);
        foreach (w[k]) w[k] = v;
    endtask

    task automatic rnd_win();
        int sel;
        sel = $urandom_range(0, 7);
        foreach (w[k]) w[k] = sel == 0 ? 15 : sel == 1 ? 0 : int'($urandom_range(0, 15));
    endtask

    initial begin
        #3;
        do_reset();
        // Directed kernel cases.
        fill(15); step(1, 1, 1, w);
        fill(0); w[4] = 8; step(1, 1, 3, w);
        fill(15); w[0] = 0; w[2] = 0; w[4] = 0; w[6] = 0; w[8] = 0; step(1, 0, 0, w);
        fill(0); w[2] = 15; w[5] = 15; w[8] = 15; step(1, 1, 4, w);
        fill(7); step(1, 0, 1, w);
        fill(7); step(1, 1, 2, w);
        // Valid pattern 1,0,1.
        rnd_win(); step(1, 0, 0, w);
        rnd_win(); step(0, 0, 0, w);
        rnd_win(); step(1, 0, 0, w);
        // Mode change without sof is ignored; sof with new mode applies at once.
        rnd_win(); step(1, 1, 0, w);
        repeat (4) begin rnd_win(); step(1, 0, 2, w); end
        rnd_win(); step(1, 1, 2, w);
        repeat (4) begin rnd_win(); step(1, 0, 0, w); end
        // Random traffic with gaps, occasional sof and mode noise.
        for (int n = 0; n < 1500; n++) begin
            rnd_win();
            step($urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 7), w);
        end
        // Reset in the middle of a stream.
        repeat (3) begin rnd_win(); step(1, 0, 0, w); end
        do_reset();
        repeat (4) begin rnd_win(); step(0, 0, 0, w); end
        // One full frame.
        n_valid = 0; n_eof = 0; eof_x = -1; eof_y = -1;
        for (int n = 0; n < IMG_W * IMG_H; n++) begin
            rnd_win();
            step(1, n == 0, $urandom_range(0, 4), w);
        end
        repeat (3) begin rnd_win(); step(0, 0, 0, w); end
        check("frame_valid_count", n_valid, IMG_W * IMG_H);
        check("frame_eof_count", n_eof, 1);
        check("frame_eof_x", eof_x, IMG_W - 1);
        check("frame_eof_y", eof_y, IMG_H - 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
